// File: rtl/text_reveal_pkg.sv
// Shared types and constants for the text reveal sequencer.
//   reveal_state_t : sequencer state
//   GLYPH_W/H      : glyph box size in px
//   SCREEN_W/H     : visible screen size in px
//   TICK_CNT_W     : width of the frame-tick counters
//   sat_len()      : clamp a requested message length to the maximum
package text_reveal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TYPING,
    ST_HOLD,
    ST_BLINK,
    ST_DONE
  } reveal_state_t;

  localparam int unsigned GLYPH_W    = 32;
  localparam int unsigned GLYPH_H    = 40;
  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned SCREEN_H   = 480;
  localparam int unsigned TICK_CNT_W = 8;

  function automatic logic [3:0] sat_len(input logic [3:0] len, input int unsigned max_len);
    if ({28'd0, len} > max_len) sat_len = 4'(max_len);
    else                        sat_len = len;
  endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// Loadable frame-tick counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : clear the count (wins over tick)
//   tick       : count one frame tick
//   limit      : number of ticks per period
//   hit        : this tick completes the period; the count restarts at 0
module frame_tick_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         tick,
  input  logic [W-1:0] limit,
  output logic         hit
);

  logic [W-1:0] count_q, count_d;

  assign hit = tick && !clr && (count_q == limit - W'(1));

  always_comb begin
    count_d = count_q;
    if (clr || hit) count_d = '0;
    else if (tick)  count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/text_reveal_ctrl.sv
// Typewriter-style message sequencer for the glyph renderers.
//   clk, rst_n          : pixel clock, async active-low reset
//   start               : latch msg_len/base_x/base_y and (re)start the sequence
//   frame_tick          : once-per-frame pulse that paces the sequence
//   msg_len             : characters to show (saturates to MAX_LEN)
//   base_x, base_y      : top-left corner of character 0
//   x, y                : current pixel
//   glyph_slot          : character slot under the previous cycle's pixel
//   glyph_x0, glyph_y0  : origin of that slot
//   glyph_en            : slot revealed, visible and pixel inside the message
//   busy                : sequence in progress
//   done                : one-cycle pulse at the end of a sequence
module text_reveal_ctrl #(
  parameter int unsigned MAX_LEN         = 8,
  parameter int unsigned PITCH_LOG2      = 6,
  parameter int unsigned GLYPH_H         = 40,
  parameter int unsigned FRAMES_PER_CHAR = 8,
  parameter int unsigned HOLD_FRAMES     = 60,
  parameter int unsigned BLINK_FRAMES    = 15,
  parameter int unsigned BLINK_TOGGLES   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       frame_tick,
  input  logic [3:0] msg_len,
  input  logic [9:0] base_x,
  input  logic [9:0] base_y,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [2:0] glyph_slot,
  output logic [9:0] glyph_x0,
  output logic [9:0] glyph_y0,
  output logic       glyph_en,
  output logic       busy,
  output logic       done
);

  import text_reveal_pkg::*;

  reveal_state_t state_q, state_d;
  logic [3:0] len_q, len_d, len_in;
  logic [9:0] base_x_q, base_x_d, base_y_q, base_y_d;
  logic [3:0] revealed_q, revealed_d;
  logic       visible_q, visible_d;
  logic [TICK_CNT_W-1:0] toggles_q, toggles_d;

  logic ctr_clr, ctr_tick, ctr_hit;
  logic [TICK_CNT_W-1:0] ctr_limit;

  assign len_in = sat_len(msg_len, MAX_LEN);

  frame_tick_counter #(.W(TICK_CNT_W)) u_tick_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ctr_clr),
    .tick  (ctr_tick),
    .limit (ctr_limit),
    .hit   (ctr_hit)
  );

  // One counter serves every timed phase; its period follows the state.
  always_comb begin
    case (state_q)
      ST_HOLD:  ctr_limit = TICK_CNT_W'(HOLD_FRAMES);
      ST_BLINK: ctr_limit = TICK_CNT_W'(BLINK_FRAMES);
      default:  ctr_limit = TICK_CNT_W'(FRAMES_PER_CHAR);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    base_x_d   = base_x_q;
    base_y_d   = base_y_q;
    revealed_d = revealed_q;
    visible_d  = visible_q;
    toggles_d  = toggles_q;
    ctr_clr    = 1'b0;
    // A tick coinciding with start is dropped: clr outranks tick in the counter.
    ctr_tick   = frame_tick && (state_q inside {ST_TYPING, ST_HOLD, ST_BLINK});

    if (start) begin
      len_d     = len_in;
      base_x_d  = base_x;
      base_y_d  = base_y;
      toggles_d = '0;
      ctr_clr   = 1'b1;
      if (len_in == '0) begin
        state_d    = ST_DONE;
        revealed_d = '0;
        visible_d  = 1'b0;
      end else begin
        state_d    = ST_TYPING;
        revealed_d = 4'd1;
        visible_d  = 1'b1;
      end
    end else begin
      case (state_q)
        ST_TYPING: begin
          if (revealed_q >= len_q) begin
            // single-character message: everything is already shown
            state_d = ST_HOLD;
            ctr_clr = 1'b1;
          end else if (ctr_hit) begin
            revealed_d = revealed_q + 4'd1;
            if (revealed_d == len_q) state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (ctr_hit) begin
            state_d   = ST_BLINK;
            toggles_d = '0;
          end
        end
        ST_BLINK: begin
          if (ctr_hit) begin
            visible_d = ~visible_q;
            toggles_d = toggles_q + TICK_CNT_W'(1);
            if (toggles_d == TICK_CNT_W'(BLINK_TOGGLES)) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          ctr_clr = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      base_x_q   <= '0;
      base_y_q   <= '0;
      revealed_q <= '0;
      visible_q  <= 1'b0;
      toggles_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      base_x_q   <= base_x_d;
      base_y_q   <= base_y_d;
      revealed_q <= revealed_d;
      visible_q  <= visible_d;
      toggles_q  <= toggles_d;
    end
  end

  assign busy = state_q inside {ST_TYPING, ST_HOLD, ST_BLINK};
  assign done = (state_q == ST_DONE);

  // Pixel stage: built from next-state values so the registered outputs
  // line up with the sequencer state that becomes current on the same edge.
  logic [10:0] dx, span, y_end;
  logic [2:0]  slot;
  logic        in_region, active_d;
  logic [2:0]  slot_d;
  logic [9:0]  x0_d, y0_d;
  logic        en_d;

  always_comb begin
    dx        = {1'b0, x} - {1'b0, base_x_d};
    span      = {7'd0, len_d} << PITCH_LOG2;
    y_end     = {1'b0, base_y_d} + 11'(GLYPH_H);
    in_region = (x >= base_x_d) && (dx < span) && (y >= base_y_d) && ({1'b0, y} < y_end);
    slot      = 3'(dx >> PITCH_LOG2);
    active_d  = state_d inside {ST_TYPING, ST_HOLD, ST_BLINK};
    slot_d    = '0;
    x0_d      = '0;
    y0_d      = '0;
    en_d      = 1'b0;
    if (in_region) begin
      slot_d = slot;
      x0_d   = base_x_d + (10'(slot) << PITCH_LOG2);
      y0_d   = base_y_d;
      en_d   = ({1'b0, slot} < revealed_d) && visible_d && active_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glyph_slot <= '0;
      glyph_x0   <= '0;
      glyph_y0   <= '0;
      glyph_en   <= 1'b0;
    end else begin
      glyph_slot <= slot_d;
      glyph_x0   <= x0_d;
      glyph_y0   <= y0_d;
      glyph_en   <= en_d;
    end
  end

endmodule

// File: doc/text_reveal_ctrl.md
# text_reveal_ctrl

Typewriter-style sequencer for the on-screen alphabet glyph renderers. It reveals a message one character at a time on frame ticks, holds it, blinks it, then retires. Per pixel, it supplies the active character slot, that slot's origin and the glyph enable to the shared glyph renderers and the character-code lookup. It sits between the game-state FSM, which issues `start`, and the pixel-stage glyph renderers.

## Interface
Parameters:
- `MAX_LEN`, 8: maximum characters per message.
- `PITCH_LOG2`, 6: character pitch is 2^PITCH_LOG2 px (64).
- `GLYPH_H`, 40: glyph box height in px.
- `FRAMES_PER_CHAR`, 8: frame ticks between successive reveals.
- `HOLD_FRAMES`, 60: frame ticks of steady display.
- `BLINK_FRAMES`, 15: frame ticks per blink phase.
- `BLINK_TOGGLES`, 6: number of visibility toggles. Must be even.

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: 1-cycle pulse that latches `msg_len`, `base_x` and `base_y` and begins the sequence.
- `frame_tick` in 1: 1-cycle pulse, once per frame, at vsync start.
- `msg_len` in 4: characters to show, 0..MAX_LEN. Values above MAX_LEN saturate to MAX_LEN.
- `base_x`, `base_y` in 10: top-left corner of character 0.
- `x`, `y` in 10: current pixel coordinates.
- `glyph_slot` out 3: index of the character under pixel (x,y).
- `glyph_x0`, `glyph_y0` out 10: origin of that slot.
- `glyph_en` out 1: the slot is revealed and visible, and the pixel is in the message region.
- `busy` out 1: a sequence is in progress.
- `done` out 1: 1-cycle pulse when the sequence ends.

## Operation
States: IDLE, TYPING, HOLD, BLINK, DONE.
- **IDLE:** `glyph_en`=0 and `busy`=0.
  - `start` with len≥1 → TYPING, with `revealed`=1, `visible`=1 and the tick counter cleared.
  - `start` with len=0 → DONE.
- **TYPING:** each `frame_tick` increments the tick counter.
  - When the counter reaches FRAMES_PER_CHAR, `revealed` increments and the counter clears.
  - When `revealed` equals len → HOLD, with the counter cleared.
- **HOLD:** after HOLD_FRAMES ticks → BLINK.
- **BLINK:** every BLINK_FRAMES ticks, `visible` toggles and the toggle counter increments.
  - After BLINK_TOGGLES toggles → DONE. `visible` ends at 1.
- **DONE:** asserts `done` for one cycle and `busy`=0, then → IDLE.
- **Restart:** `start` in any non-IDLE state restarts from TYPING with the newly latched values. No `done` is emitted for the aborted sequence.
- **Simultaneous events:** if `start` and `frame_tick` arrive in the same cycle, `start` wins and the tick is discarded.

Pixel path. All arithmetic is 11-bit unsigned, so there is no wrap.
- `dx` = x − base_x.
- Region: x≥base_x, dx < len·2^PITCH_LOG2, and base_y ≤ y < base_y+GLYPH_H. The region clips at x=1023 and y=1023 with no wrap-around.
- `slot` = dx >> PITCH_LOG2.
- `glyph_x0` = base_x + (slot << PITCH_LOG2). `glyph_y0` = base_y.
- `glyph_en` = region ∧ slot<revealed ∧ visible ∧ (state ∈ {TYPING, HOLD, BLINK}).
- Outside the region, `glyph_slot`, `glyph_x0` and `glyph_y0` are 0.

## Timing
- **Reset:** every output is 0, state is IDLE, and `revealed`, `visible` and all counters are 0. Reset mid-sequence aborts it immediately with no `done` pulse.
- **Pixel path:** registered, so outputs correspond to the (x,y) of the previous cycle (1-cycle latency). The renderers must delay x,y by 1 cycle to match.
- **State change:** the state register updates on the edge after `start` or the qualifying `frame_tick`. The pixel path uses the post-edge `revealed` and `visible` values.
- **Sequence length:** for len=L, `done` pulses (L−1)·FRAMES_PER_CHAR + HOLD_FRAMES + BLINK_TOGGLES·BLINK_FRAMES ticks after `start`, on the cycle after the final qualifying tick.
- **`busy`:** rises on the cycle after `start`, and falls in the same cycle that `done` rises.

## Structure
- Package `text_reveal_pkg` holds:
  - the state enum `reveal_state_t`;
  - `GLYPH_W`=32 and `GLYPH_H`=40;
  - `SCREEN_W`=640 and `SCREEN_H`=480.
- Sub-module `frame_tick_counter`: a loadable tick counter with `clr`, `tick`, a `limit` input and a `hit` output. One instance is reused across TYPING, HOLD and BLINK.
- The pixel-path register stage lives in the top level.

## Test plan
- **Basic reveal:** `msg_len`=3, `base_x`=100, `base_y`=200, `start`, 8 ticks.
  - Pixel (170,210) → `glyph_slot`=1, `glyph_x0`=164, `glyph_en`=1.
  - Pixel (230,210) → `glyph_en`=0 until tick 16.
- **Full sequence:** `msg_len`=2 → `done` after exactly 8+60+90=158 ticks; `busy` was high throughout.
- **Blink:** in BLINK, `glyph_en` at (101,201) alternates 0/1 every 15 ticks, and is 1 on the last cycle before DONE.
- **Boundary:** `base_x`=1000, `msg_len`=8 → x=1023 gives `glyph_en`=1 for slot 0, and no slot >0 ever appears. `msg_len`=0 → `done` on the cycle after `start`.
- **Collision:** `start` and `frame_tick` in the same cycle → `revealed`=1 and tick count 0. A second `start` mid-HOLD → back to TYPING with new `base_x` and no `done`.
- **Reset:** assert `rst_n`=0 mid-TYPING → outputs go to 0 asynchronously (before the next edge). After release, the block stays IDLE until `start`.
